alu_control_md: RTL and testbench
=================================

ALU_CONTROL_MD -- requirements
Module: alu_control_md

Interface
REQ-001 XLEN, 32: operand/result width; legal values 32 or 64.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 valid_in  in  1  EX-stage instruction present.
REQ-005 flush  in  1  kill in-flight instruction (branch mispredict, hazard flush).
REQ-006 ALUOp_in  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-007 instruction  in  32  full instruction word; func7=[31:25], func3=[14:12].
REQ-008 op_a, op_b  in  XLEN each  source operands; op_b already muxed with immediate.
REQ-009 ALUControl_out  out  4  decoded ALU operation.
REQ-010 result  out  XLEN  execute result.
REQ-011 result_valid  out  1  result is valid this cycle.
REQ-012 stall_out  out  1  hold IF/ID/EX; upstream keeps all inputs stable while high.

Function
REQ-013 ALUControl_out codes SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, MDU 1111.
REQ-014 Decode: ALUOp 00 -> ADD; 01 -> SUB; 10 -> func7/func3 per RV32I R-type (func7 0100000 selects SUB/SRA); 11 -> func3 only, func7 ignored except instruction[30] for SRLI/SRAI; func7 0000001 with ALUOp 10 -> MDU; unlisted encodings -> ADD.
REQ-015 Non-MDU ops SHALL be combinational: result = op(op_a, op_b), result_valid = valid_in & ~flush, stall_out = 0; shift amount = op_b[log2(XLEN)-1:0].
REQ-016 FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-017 IDLE: valid_in & MDU & ~flush -> capture operands and func3, stall_out=1 that cycle; func3 0xx -> MUL, 1xx -> DIV.
REQ-018 MUL: radix-2 shift-add, one bit per cycle, exactly XLEN cycles, then DONE; MUL/MULH/MULHSU/MULHU per func3 using magnitudes plus sign correction.
REQ-019 DIV: restoring division, one quotient bit per cycle, exactly XLEN cycles, then DONE; DIV/DIVU/REM/REMU per func3; quotient sign = sign(a) xor sign(b), remainder sign = sign(a).
REQ-020 Divide by zero: skip iteration, go IDLE -> DONE next cycle; quotient all ones, remainder = op_a.
REQ-021 Signed overflow (op_a = most negative, op_b = -1, DIV/REM): same fast path; quotient = op_a, remainder 0.
REQ-022 stall_out SHALL be 1 in accepting IDLE cycle and throughout MUL/DIV; 0 in DONE.
REQ-023 DONE: result = held MDU result, result_valid = 1 for exactly one cycle, return to IDLE; the still-present instruction SHALL NOT be relaunched.
REQ-024 Iterative latency: accept at cycle T, result_valid at T+XLEN+1; fast path at T+1.
REQ-025 flush in any state SHALL return FSM to IDLE next edge with no result_valid; flush wins over simultaneous accept.
REQ-026 Operand/func3 changes while stall_out=1 SHALL be ignored (captured copies used).

Reset
REQ-027 rst SHALL asynchronously force state IDLE, counter 0, internal operand/accumulator registers 0.
REQ-028 During and after reset until next accept: stall_out=0, result_valid=valid_in for non-MDU ops, no MDU result emitted; reset mid-operation discards it.

Structure
REQ-029 Shared package holds ALUOp encodings, ALUControl codes, MDU func3 codes, FSM state type.
REQ-030 One sub-module, mdu_iter, SHALL contain the counter, accumulator and shift datapath; decode and FSM stay in alu_control_md.

Verification
REQ-031 ALUOp 10, func7 0100000, func3 000, a=5, b=7 -> ALUControl 0110, result 0xFFFFFFFE, no stall.
REQ-032 MUL a=-3, b=7, XLEN=32 -> stall 33 cycles, result 0xFFFFFFEB valid one cycle; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 DIV a=-7, b=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; latency 33.
REQ-034 DIVU a=9, b=0 -> 0xFFFFFFFF at T+1; DIV 0x80000000/-1 -> 0x80000000, REM 0.
REQ-035 flush at iteration 10 of a DIV, then ADD 1+1 next cycle -> no MDU result_valid, result 2 with stall 0.
REQ-036 rst asserted mid-MUL (asynchronously, between edges) -> stall_out 0 immediately, IDLE, no result_valid after release.

Source files
------------

// File: rtl/alu_control_md_pkg.sv
// Shared encodings for the EX-stage ALU control and the iterative multiply/divide unit.
package alu_control_md_pkg;

    typedef enum logic [1:0] {
        OP_MEM    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_RTYPE  = 2'b10,
        OP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_MDU  = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } mdu_f3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    // RV32I base-integer func3 table; alt selects SRA over SRL.
    function automatic alu_ctrl_e base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_md_mdu.sv
// Iterative multiply/divide datapath: captured operands, iteration counter and
// shared accumulator for radix-2 shift-add multiply and restoring division.
module mdu_iter
    import alu_control_md_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            fast,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int unsigned    CW       = $clog2(XLEN);
    localparam logic [CW-1:0]  LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        f3;
    logic              neg_q;
    logic              neg_r;

    logic              is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;

    always_comb begin
        is_div   = func3[2];
        a_signed = is_div ? ~func3[0] : (func3 == F3_MULH || func3 == F3_MULHSU);
        b_signed = is_div ? ~func3[0] : (func3 == F3_MULH);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        div_zero = (op_b == '0);
        div_ovf  = ~func3[0] & (op_a == MOST_NEG) & (op_b == '1);
        fast     = is_div & (div_zero | div_ovf);
    end

    // acc holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide.
    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        rem_shift = acc[2*XLEN-1:XLEN-1];
        rem_diff  = rem_shift - {1'b0, opnd};
        q_bit     = (rem_shift >= {1'b0, opnd});
        div_next  = {q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0], acc[XLEN-2:0], q_bit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            f3    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            f3    <= func3;
            opnd  <= is_div ? b_mag : a_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= is_div & a_neg;
            if (!is_div) begin
                acc <= {{XLEN{1'b0}}, b_mag};
            end else if (div_zero) begin
                acc   <= {op_a, {XLEN{1'b1}}};
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else if (div_ovf) begin
                acc   <= {{XLEN{1'b0}}, op_a};
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                acc <= {{XLEN{1'b0}}, a_mag};
            end
        end else if (step) begin
            cnt <= cnt + 1'b1;
            acc <= f3[2] ? div_next : mul_next;
        end
    end

    assign last = (cnt == LAST_CNT);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (f3[2])
            result = f3[1] ? rem : quo;
        else
            result = (f3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control: decodes ALUOp/func fields, executes single-cycle ops and
// sequences the iterative multiply/divide unit, stalling upstream while it runs.
module alu_control_md
    import alu_control_md_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [1:0]      ALUOp_in,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ALUControl_out,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            stall_out
);
    localparam int unsigned SH = $clog2(XLEN);

    logic [6:0] func7;
    logic [2:0] func3;
    logic       unused_bits;
    assign func7       = instruction[31:25];
    assign func3       = instruction[14:12];
    assign unused_bits = ^{instruction[24:15], instruction[11:0]};

    alu_ctrl_e ctrl;

    always_comb begin
        ctrl = ALU_ADD;
        case (ALUOp_in)
            OP_MEM:    ctrl = ALU_ADD;
            OP_BRANCH: ctrl = ALU_SUB;
            OP_RTYPE: begin
                if (func7 == F7_MDU)
                    ctrl = ALU_MDU;
                else if (func7 == F7_BASE)
                    ctrl = base_op(func3, 1'b0);
                else if (func7 == F7_ALT && func3 == 3'b000)
                    ctrl = ALU_SUB;
                else if (func7 == F7_ALT && func3 == 3'b101)
                    ctrl = ALU_SRA;
            end
            OP_ITYPE:  ctrl = base_op(func3, instruction[30]);
        endcase
    end

    assign ALUControl_out = ctrl;

    logic [SH-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    assign shamt = op_b[SH-1:0];

    always_comb begin
        alu_res = '0;
        case (ctrl)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:  alu_res = '0;
        endcase
    end

    state_e          state;
    logic            busy, is_mdu, accept, mdu_fast, mdu_last;
    logic [XLEN-1:0] mdu_res;

    assign busy   = (state == S_MUL) || (state == S_DIV);
    assign is_mdu = (ctrl == ALU_MDU);
    // rst gates accept so a held MDU instruction cannot raise stall while in reset.
    assign accept = (state == S_IDLE) && valid_in && !flush && !rst && is_mdu;

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (accept),
        .step   (busy && !flush),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .fast   (mdu_fast),
        .last   (mdu_last),
        .result (mdu_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (accept) state <= func3[2] ? (mdu_fast ? S_DONE : S_DIV) : S_MUL;
                S_MUL, S_DIV: if (mdu_last) state <= S_DONE;
                S_DONE:       state <= S_IDLE;
                default:      state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_out    = accept || busy;
        result       = alu_res;
        result_valid = 1'b0;
        case (state)
            S_IDLE: result_valid = valid_in && !flush && !is_mdu;
            S_DONE: begin
                result       = mdu_res;
                result_valid = !flush;
            end
            default: result_valid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_control_md.sv
// Scoreboard bench for alu_control_md: driver pushes reference-model expectations,
// a negedge monitor pops them whenever result_valid is seen.
module tb_alu_control_md;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned ITER_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst, valid_in, flush;
    logic [1:0]      ALUOp_in;
    logic [31:0]     instruction;
    logic [XLEN-1:0] op_a, op_b;
    logic [3:0]      ALUControl_out;
    logic [XLEN-1:0] result;
    logic            result_valid, stall_out;

    alu_control_md #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .flush          (flush),
        .ALUOp_in       (ALUOp_in),
        .instruction    (instruction),
        .op_a           (op_a),
        .op_b           (op_b),
        .ALUControl_out (ALUControl_out),
        .result         (result),
        .result_valid   (result_valid),
        .stall_out      (stall_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  code;
        int unsigned due;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [3:0] rtab [8] = '{4'h2, 4'h4, 4'h8, 4'h9, 4'h3, 4'h5, 4'h1, 4'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mdu_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b, output int unsigned lat);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic signed [31:0] qa, qb;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        qa  = a;
        qb  = b;
        lat = ITER_LAT;
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            default: begin
                if (b == 32'd0) begin
                    lat = 1;
                    return f3[1] ? a : 32'hFFFF_FFFF;
                end
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    return f3[1] ? 32'd0 : a;
                end
                case (f3)
                    3'd4:    return qa / qb;
                    3'd5:    return a / b;
                    3'd6:    return qa % qb;
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] ins,
                                              input logic [31:0] a, input logic [31:0] b,
                                              output logic [3:0] code, output int unsigned lat);
        logic [6:0] f7;
        logic [2:0] f3;
        f7  = ins[31:25];
        f3  = ins[14:12];
        lat = 0;
        case (op)
            2'b00: code = 4'h2;
            2'b01: code = 4'h6;
            2'b10: begin
                if (f7 == 7'h01) begin
                    code = 4'hF;
                    return mdu_model(f3, a, b, lat);
                end
                if (f7 == 7'h00)                     code = rtab[f3];
                else if (f7 == 7'h20 && f3 == 3'd0)  code = 4'h6;
                else if (f7 == 7'h20 && f3 == 3'd5)  code = 4'h7;
                else                                 code = 4'h2;
            end
            default: code = (f3 == 3'd5 && ins[30]) ? 4'h7 : rtab[f3];
        endcase
        case (code)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h3:    return a ^ b;
            4'h4:    return a << b[4:0];
            4'h5:    return a >> b[4:0];
            4'h6:    return a - b;
            4'h7:    return $signed(a) >>> b[4:0];
            4'h8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9:    return (a < b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'h0, f3, 12'h033};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result_valid", 64'(result_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", 64'(result), 64'(mon_e.res));
                chk("alu_control", 64'(ALUControl_out), 64'(mon_e.code));
                chk("valid_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input bit scramble);
        exp_t        e;
        int unsigned lat;
        int unsigned stalls;
        @(posedge clk); #1;
        flush       = 1'b0;
        valid_in    = 1'b1;
        ALUOp_in    = op;
        instruction = ins;
        op_a        = a;
        op_b        = b;
        e.res = ref_model(op, ins, a, b, e.code, lat);
        e.due = cyc + lat;
        exp_q.push_back(e);
        stalls = 0;
        @(negedge clk);
        while (stall_out === 1'b1 && stalls < 200) begin
            stalls++;
            @(posedge clk); #1;
            if (scramble) begin
                op_a = $urandom;
                op_b = $urandom;
            end
            @(negedge clk);
        end
        chk("stall_cycles", 64'(stalls), 64'(lat));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            flush    = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
        ALUOp_in = 2'b00; instruction = 32'd0; op_a = '0; op_b = '0;
        #2;
        chk("reset_stall", 64'(stall_out), 64'd0);
        chk("reset_valid", 64'(result_valid), 64'd0);
        issue(2'b00, 32'h0000_0003, 32'd3, 32'd4, 1'b0);
        idle(1);
        rst = 1'b0;
        idle(2);

        issue(2'b10, mk(7'h20, 3'd0), 32'd5, 32'd7, 1'b0);
        chk("sub_anchor", 64'(result), 64'hFFFF_FFFE);
        chk("sub_code", 64'(ALUControl_out), 64'h6);
        issue(2'b10, mk(7'h01, 3'd0), 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mul_anchor", 64'(result), 64'hFFFF_FFEB);
        issue(2'b10, mk(7'h01, 3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mulhu_anchor", 64'(result), 64'hFFFF_FFFE);
        issue(2'b10, mk(7'h01, 3'd4), 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_anchor", 64'(result), 64'hFFFF_FFFD);
        issue(2'b10, mk(7'h01, 3'd6), 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("rem_anchor", 64'(result), 64'hFFFF_FFFF);
        issue(2'b10, mk(7'h01, 3'd5), 32'd9, 32'd0, 1'b0);
        chk("divu_zero_anchor", 64'(result), 64'hFFFF_FFFF);
        issue(2'b10, mk(7'h01, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_anchor", 64'(result), 64'h8000_0000);
        issue(2'b10, mk(7'h01, 3'd6), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("rem_ovf_anchor", 64'(result), 64'h0);
        idle(1);

        // flush during the tenth divide iteration, then an ADD the very next cycle
        @(posedge clk); #1;
        valid_in = 1'b1; ALUOp_in = 2'b10; instruction = mk(7'h01, 3'd4);
        op_a = 32'd100; op_b = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        chk("div_busy_stall", 64'(stall_out), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_valid", 64'(result_valid), 64'd0);
        issue(2'b00, 32'h0000_0003, 32'd1, 32'd1, 1'b0);
        chk("flush_then_add", 64'(result), 64'd2);
        idle(1);

        // asynchronous reset between edges in the middle of a multiply
        @(posedge clk); #1;
        valid_in = 1'b1; ALUOp_in = 2'b10; instruction = mk(7'h01, 3'd0);
        op_a = 32'hFFFF_FFFD; op_b = 32'd7;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1; valid_in = 1'b0;
        #1;
        chk("async_reset_stall", 64'(stall_out), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        idle(40);
        issue(2'b11, mk(7'h00, 3'd6), 32'h0F0F_0000, 32'h0000_00F0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            logic [1:0] op;
            logic [6:0] f7;
            logic [2:0] f3;
            op = 2'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2, 3:    f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            issue(op, {f7, 10'($urandom), f3, 12'($urandom)}, pick(), pick(), 1'b1);
            if ($urandom_range(0, 5) == 0) idle(1);
        end

        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
